dmem_port_arbiter: RTL and testbench

- Controller and arbiter in front of the 16x32 dual-port distributed data memory (sync write port a/d/we, async read port dpra/dpo).
- Shares the memory among N requesters. Write port and read port are arbitrated independently, so one write and one read can be serviced per cycle.
- After reset, scrubs every memory word to zero before accepting traffic.
- Returns read data one cycle after grant, with a registered response.

---
 rtl/dmem_port_arbiter_pkg.sv | 9 +
 rtl/dmem_port_arbiter_if.sv | 37 +++
 rtl/dmem_port_arbiter_rr_arbiter.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {SCRUB, RUN} dmem_arb_state_t;

  localparam int DMEM_DW_DEF = 32;
  localparam int DMEM_AW_DEF = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory port arbiter.
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = DMEM_DW_DEF,
  parameter int AW = DMEM_AW_DEF
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic [AW-1:0]   mem_a;
  logic [DW-1:0]   mem_d;
  logic            mem_we;
  logic [AW-1:0]   mem_dpra;
  logic [DW-1:0]   mem_dpo;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dpo,
    output req_ready, rsp_valid, rsp_rdata, init_done,
           mem_a, mem_d, mem_we, mem_dpra
  );

  // Requesters plus memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dpo,
    input  req_ready, rsp_valid, rsp_rdata, init_done,
           mem_a, mem_d, mem_we, mem_dpra
  );

endinterface

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, which
// moves past the winner whenever advance is high and something is granted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;
  int            gidx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    gidx  = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        found         = 1'b1;
        gidx          = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) ptr_d = PW'((gidx + 1) % N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Scrubbing controller and dual round-robin arbiter for a 2**AW x DW
// distributed RAM. Optional write-to-read forwarding: `define DMEM_ARB_FWD_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = DMEM_DW_DEF,
  parameter int AW = DMEM_AW_DEF
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);
  dmem_arb_state_t state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]   wr_addr, rd_addr, mem_a_c;
  logic [DW-1:0]   wr_data, rd_data, mem_d_c;
  logic            run, wr_fire, rd_fire, mem_we_c;

  assign run    = (state_q == RUN);
  assign wr_req = bus.req_valid & bus.req_we;
  assign rd_req = bus.req_valid & ~bus.req_we;

  // Pointers only move once traffic is accepted, so they sit at 0 through the scrub.
  rr_arbiter #(.N(N)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (run),
    .gnt     (wr_gnt)
  );

  rr_arbiter #(.N(N)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (run),
    .gnt     (rd_gnt)
  );

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (wr_gnt[i]) begin
        wr_addr = bus.req_addr[i*AW +: AW];
        wr_data = bus.req_wdata[i*DW +: DW];
      end
      if (rd_gnt[i]) rd_addr = bus.req_addr[i*AW +: AW];
    end
  end

  assign wr_fire = run & (|wr_gnt);
  assign rd_fire = run & (|rd_gnt);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_we_c = 1'b0;
    mem_a_c  = '0;
    mem_d_c  = '0;
    case (state_q)
      SCRUB: begin
        // Write enable is gated by rst itself so no stray write lands during reset.
        mem_we_c = ~rst;
        mem_a_c  = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = RUN;
      end
      RUN: begin
        mem_we_c = wr_fire;
        mem_a_c  = wr_addr;
        mem_d_c  = wr_data;
      end
      default: state_d = SCRUB;
    endcase
  end

`ifdef DMEM_ARB_FWD_EN
  assign rd_data = (wr_fire && rd_fire && (wr_addr == rd_addr)) ? wr_data : bus.mem_dpo;
`else
  assign rd_data = bus.mem_dpo;
`endif

  assign rsp_valid_d = rd_fire ? rd_gnt : '0;
  assign rsp_rdata_d = rd_fire ? rd_data : rsp_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCRUB;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = run ? (wr_gnt | rd_gnt) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.init_done = run;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_a     = mem_a_c;
  assign bus.mem_d     = mem_d_c;
  assign bus.mem_dpra  = run ? rd_addr : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural RAM, shadow memory and a response scoreboard.
module tb_dmem_port_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 2**AW;

  logic clk = 1'b0;
  logic rst;
  logic ram_junk;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  dmem_port_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] ram    [D];
  logic [DW-1:0] shadow [D];

  always @(posedge clk) begin
    if (ram_junk) begin
      for (int i = 0; i < D; i++) ram[i] <= 32'hBAD0_0000 | i;
    end else if (bus.mem_we) begin
      ram[bus.mem_a] <= bus.mem_d;
    end
  end
  assign bus.mem_dpo = ram[bus.mem_dpra];

  typedef struct {
    int            due;
    logic [N-1:0]  v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard: every cycle either an expected response or silence.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_valid !== e.v || bus.rsp_rdata !== e.d) begin
          errors++;
          $display("FAIL rsp cyc=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                   cyc, bus.rsp_valid, bus.rsp_rdata, e.v, e.d);
        end
      end else begin
        checks++;
        if (bus.rsp_valid !== '0) begin
          errors++;
          $display("FAIL rsp_idle cyc=%0d: got valid=%b, expected 00", cyc, bus.rsp_valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_valid[i]            = v;
    bus.req_we[i]               = we;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ram_junk = 1'b1;
    set_req(0, 1, 1, 4'd12, 32'hCAFE_0000);
    set_req(1, 1, 1, 4'd13, 32'hCAFE_0001);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00 || bus.init_done !== 1'b0 || bus.rsp_valid !== 2'b00 ||
        bus.rsp_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b init=%b rspv=%b rdata=%h we=%b, expected 00 0 00 0 0",
               bus.req_ready, bus.init_done, bus.rsp_valid, bus.rsp_rdata, bus.mem_we);
    end
    tick();
    rst = 1'b0;
    ram_junk = 1'b0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b00 || bus.mem_we !== 1'b1 || bus.mem_a !== AW'(k) ||
          bus.mem_d !== 32'h0 || bus.init_done !== 1'b0) begin
        errors++;
        $display("FAIL scrub[%0d]: ready=%b we=%b a=%0d d=%h init=%b, expected 00 1 %0d 0 0",
                 k, bus.req_ready, bus.mem_we, bus.mem_a, bus.mem_d, bus.init_done, k);
      end
      tick();
    end
    clear_reqs();
    for (int i = 0; i < D; i++) shadow[i] = '0;
    @(negedge clk);
    checks++;
    if (bus.init_done !== 1'b1 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL init_done: got init=%b ready=%b, expected 1 00", bus.init_done, bus.req_ready);
    end
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_write_alternate();
    set_req(0, 1, 1, 4'd10, 32'h0A0A_0A0A);
    set_req(1, 1, 1, 4'd11, 32'h0B0B_0B0B);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || bus.mem_we !== 1'b1 ||
          bus.mem_a !== ((k % 2 == 0) ? 4'd10 : 4'd11) ||
          bus.mem_d !== ((k % 2 == 0) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B)) begin
        errors++;
        $display("FAIL wr_alt[%0d]: ready=%b we=%b a=%0d d=%h", k, bus.req_ready, bus.mem_we,
                 bus.mem_a, bus.mem_d);
      end
      tick();
    end
    shadow[10] = 32'h0A0A_0A0A;
    shadow[11] = 32'h0B0B_0B0B;
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_a !== 4'd0 || bus.mem_d !== 32'h0) begin
      errors++;
      $display("FAIL wr_idle: we=%b a=%0d d=%h, expected 0 0 0", bus.mem_we, bus.mem_a, bus.mem_d);
    end
    tick();
  endtask

  task automatic test_write_read();
    set_req(0, 1, 1, 4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_a !== 4'd3 || bus.mem_d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr3: ready=%b a=%0d d=%h, expected 01 3 deadbeef", bus.req_ready, bus.mem_a, bus.mem_d);
    end
    shadow[3] = 32'hDEAD_BEEF;
    tick();
    set_req(0, 1, 0, 4'd3, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_dpra !== 4'd3 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rd3: ready=%b dpra=%0d we=%b, expected 01 3 0", bus.req_ready, bus.mem_dpra, bus.mem_we);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b01, d: shadow[3]});
    tick();
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_concurrent();
    set_req(1, 1, 1, 4'd9, 32'hA5A5_A5A5);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL wr9: ready=%b, expected 10", bus.req_ready);
    end
    shadow[9] = 32'hA5A5_A5A5;
    tick();
    set_req(0, 1, 1, 4'd5, 32'h1111_1111);
    set_req(1, 1, 0, 4'd9, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b11 || bus.mem_a !== 4'd5 || bus.mem_dpra !== 4'd9) begin
      errors++;
      $display("FAIL wr_rd_concurrent: ready=%b a=%0d dpra=%0d, expected 11 5 9",
               bus.req_ready, bus.mem_a, bus.mem_dpra);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b10, d: shadow[9]});
    shadow[5] = 32'h1111_1111;
    tick();
    set_req(0, 1, 0, 4'd5, 32'h0);
    set_req(1, 0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rd5: ready=%b, expected 01", bus.req_ready);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b01, d: shadow[5]});
    tick();
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] want;
`ifdef DMEM_ARB_FWD_EN
    want = 32'h1234_5678;
`else
    want = shadow[7];
`endif
    set_req(0, 1, 1, 4'd7, 32'h1234_5678);
    set_req(1, 1, 0, 4'd7, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b11) begin
      errors++;
      $display("FAIL same_addr_grant: ready=%b, expected 11", bus.req_ready);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b10, d: want});
    shadow[7] = 32'h1234_5678;
    tick();
    set_req(0, 0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rd7_again: ready=%b, expected 10", bus.req_ready);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b10, d: shadow[7]});
    tick();
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 2; a++) begin
      set_req(0, 1, 1, AW'(a), 32'h0101_0101 * a);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL b2b_wr%0d: ready=%b, expected 01", a, bus.req_ready);
      end
      shadow[a] = 32'h0101_0101 * a;
      tick();
    end
    clear_reqs();
    for (int a = 1; a <= 3; a++) begin
      set_req(1, 1, 0, AW'(a), 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10 || bus.mem_dpra !== AW'(a)) begin
        errors++;
        $display("FAIL b2b_rd%0d: ready=%b dpra=%0d, expected 10 %0d", a, bus.req_ready, bus.mem_dpra, a);
      end
      exp_q.push_back('{due: cyc + 1, v: 2'b10, d: shadow[a]});
      tick();
    end
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_read_round_robin();
    set_req(0, 1, 0, 4'd10, 32'h0);
    set_req(1, 1, 0, 4'd11, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rd_rr[%0d]: ready=%b, expected %b", k, bus.req_ready,
                 (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      exp_q.push_back('{due: cyc + 1, v: (k % 2 == 0) ? 2'b01 : 2'b10,
                        d: (k % 2 == 0) ? shadow[10] : shadow[11]});
      tick();
    end
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1, 0, 4'd3, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rd_before_rst: ready=%b, expected 01", bus.req_ready);
    end
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < D; i++) shadow[i] = '0;
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.init_done !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst: rspv=%b init=%b rdata=%h, expected 00 0 0",
               bus.rsp_valid, bus.init_done, bus.rsp_rdata);
    end
    rst = 1'b0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_a !== AW'(k) || bus.mem_d !== 32'h0 || bus.init_done !== 1'b0) begin
        errors++;
        $display("FAIL rescrub[%0d]: we=%b a=%0d d=%h init=%b, expected 1 %0d 0 0",
                 k, bus.mem_we, bus.mem_a, bus.mem_d, bus.init_done, k);
      end
      tick();
    end
    set_req(0, 1, 0, 4'd3, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.init_done !== 1'b1 || bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rd3_after_rst: init=%b ready=%b, expected 1 01", bus.init_done, bus.req_ready);
    end
    exp_q.push_back('{due: cyc + 1, v: 2'b01, d: shadow[3]});
    tick();
    clear_reqs();
    @(negedge clk);
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write_alternate();
    test_write_read();
    test_concurrent();
    test_same_addr();
    test_back_to_back();
    test_read_round_robin();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
